// File: rtl/deja_glitch_power_multi.sv
// deja_glitch_power_multi: multi-channel power glitcher.
// One sweep engine drives CHANNELS glitch outputs. Each test cycle (run_i high)
// emits PULSES pulses of `size` clocks, the first one `offset` clocks into the
// window and the rest GAP clocks apart. The sweep walks the offset (iter) first
// and then the width (size += size_step), stopping once size exceeds size_max.
// Ports:
//   clk_i, rst_n_i          clock, asynchronous active-low reset
//   stb_i/we_i/adr_i/dat_i  8-bit wishbone slave request
//   ack_o/dat_o             single-cycle ack with read data
//   run_i                   test-cycle window from the target sequencer
//   glitch_o                per-channel glitch drive (idle level = pol[ch])
//   finished_o              sticky sweep-complete flag
module deja_glitch_power_multi #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                stb_i,
    input  logic                we_i,
    input  logic [3:0]          adr_i,
    input  logic [7:0]          dat_i,
    output logic                ack_o,
    output logic [7:0]          dat_o,
    input  logic                run_i,
    output logic [CHANNELS-1:0] glitch_o,
    output logic                finished_o
);

    localparam int unsigned SZ_W     = 9;
    localparam logic [3:0]  ADR_LAST = 4'd13;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_PULSE,
        S_GAP,
        S_HOLD,
        S_ADVANCE
    } state_t;

    state_t state;

    // Software-visible configuration
    logic [7:0]  size_reg;
    logic [7:0]  step_reg;
    logic [7:0]  ch_en_reg;
    logic [7:0]  pol_reg;
    logic [15:0] iter_max_reg;
    logic [7:0]  size_step_reg;
    logic [7:0]  size_max_reg;
    logic [7:0]  pulses_reg;
    logic [7:0]  gap_reg;

    // Sweep state
    logic [SZ_W-1:0]  cur_size;
    logic [15:0]      iter;
    logic [CNT_W-1:0] offset;
    logic             trunc;

    // Per test-cycle state
    logic [CNT_W-1:0]    run_cnt;
    logic [SZ_W-1:0]     ph;
    logic [7:0]          pulses_left;

    // Configuration captured at the start of a test cycle
    logic [7:0]          sh_step;
    logic [CHANNELS-1:0] sh_en;
    logic [CHANNELS-1:0] sh_pol;
    logic [15:0]         sh_iter_max;
    logic [7:0]          sh_size_step;
    logic [7:0]          sh_size_max;
    logic [7:0]          sh_gap;

    // Bus decode; ack_o gating keeps a held strobe from acking back-to-back
    logic wb_hit_c;
    logic wr_en_c;
    logic restart_c;
    logic busy_c;
    logic [7:0] rd_data_c;

    assign wb_hit_c  = stb_i && !ack_o && (adr_i <= ADR_LAST);
    assign wr_en_c   = wb_hit_c && we_i;
    assign restart_c = wr_en_c && (adr_i == 4'd3) && dat_i[0];
    assign busy_c    = (state != S_IDLE);

    // Sweep arithmetic
    logic [CNT_W:0]     off_sum_c;
    logic [CNT_W-1:0]   off_next_c;
    logic [CNT_W-1:0]   run_cnt_inc_c;
    logic [SZ_W-1:0]    size_sum_c;

    assign off_sum_c     = {1'b0, offset} + (CNT_W+1)'(sh_step);
    assign off_next_c    = off_sum_c[CNT_W] ? CNT_MAX : off_sum_c[CNT_W-1:0];
    assign run_cnt_inc_c = (run_cnt == CNT_MAX) ? run_cnt : run_cnt + CNT_W'(1);
    assign size_sum_c    = cur_size + SZ_W'(sh_size_step);

    // Output levels: live config while idle (shadow loads on that same edge)
    logic [CHANNELS-1:0] idle_lvl_c;
    logic [CHANNELS-1:0] pulse_lvl_c;

    assign idle_lvl_c  = (state == S_IDLE) ? pol_reg[CHANNELS-1:0] : sh_pol;
    assign pulse_lvl_c = idle_lvl_c ^ ((state == S_IDLE) ? ch_en_reg[CHANNELS-1:0] : sh_en);

    // Configuration register writes
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            size_reg      <= 8'd1;
            step_reg      <= 8'd1;
            ch_en_reg     <= 8'hFF;
            pol_reg       <= 8'hFF;
            iter_max_reg  <= 16'd0;
            size_step_reg <= 8'd1;
            size_max_reg  <= 8'd1;
            pulses_reg    <= 8'd1;
            gap_reg       <= 8'd1;
        end else if (wr_en_c) begin
            case (adr_i)
                4'd0:    size_reg           <= dat_i;
                4'd1:    step_reg           <= dat_i;
                4'd4:    ch_en_reg          <= dat_i;
                4'd5:    pol_reg            <= dat_i;
                4'd6:    iter_max_reg[7:0]  <= dat_i;
                4'd7:    iter_max_reg[15:8] <= dat_i;
                4'd8:    size_step_reg      <= dat_i;
                4'd9:    size_max_reg       <= dat_i;
                4'd12:   pulses_reg         <= dat_i;
                4'd13:   gap_reg            <= dat_i;
                default: ;
            endcase
        end
    end

    // Read data mux
    always_comb begin
        rd_data_c = 8'h00;
        case (adr_i)
            4'd0:    rd_data_c = size_reg;
            4'd1:    rd_data_c = step_reg;
            4'd2:    rd_data_c = {5'b0, trunc, busy_c, finished_o};
            4'd4:    rd_data_c = ch_en_reg;
            4'd5:    rd_data_c = pol_reg;
            4'd6:    rd_data_c = iter_max_reg[7:0];
            4'd7:    rd_data_c = iter_max_reg[15:8];
            4'd8:    rd_data_c = size_step_reg;
            4'd9:    rd_data_c = size_max_reg;
            4'd10:   rd_data_c = iter[7:0];
            4'd11:   rd_data_c = iter[15:8];
            4'd12:   rd_data_c = pulses_reg;
            4'd13:   rd_data_c = gap_reg;
            default: rd_data_c = 8'h00;
        endcase
    end

    // Bus response
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            ack_o <= 1'b0;
            dat_o <= 8'h00;
        end else begin
            ack_o <= wb_hit_c;
            dat_o <= (wb_hit_c && !we_i) ? rd_data_c : 8'h00;
        end
    end

    // Glitch sequencer and sweep engine
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state        <= S_IDLE;
            glitch_o     <= '1;
            finished_o   <= 1'b0;
            trunc        <= 1'b0;
            cur_size     <= SZ_W'(1);
            iter         <= 16'd0;
            offset       <= '0;
            run_cnt      <= '0;
            ph           <= '0;
            pulses_left  <= 8'd0;
            sh_step      <= 8'd1;
            sh_en        <= '1;
            sh_pol       <= '1;
            sh_iter_max  <= 16'd0;
            sh_size_step <= 8'd1;
            sh_size_max  <= 8'd1;
            sh_gap       <= 8'd1;
        end else if (restart_c) begin
            // Restart wins over whatever the sequencer was doing
            state      <= S_IDLE;
            glitch_o   <= pol_reg[CHANNELS-1:0];
            finished_o <= 1'b0;
            trunc      <= 1'b0;
            cur_size   <= SZ_W'(size_reg);
            iter       <= 16'd0;
            offset     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    glitch_o <= idle_lvl_c;
                    if (run_i && !finished_o) begin
                        sh_step      <= step_reg;
                        sh_en        <= ch_en_reg[CHANNELS-1:0];
                        sh_pol       <= pol_reg[CHANNELS-1:0];
                        sh_iter_max  <= iter_max_reg;
                        sh_size_step <= size_step_reg;
                        sh_size_max  <= size_max_reg;
                        sh_gap       <= (gap_reg == 8'd0) ? 8'd1 : gap_reg;
                        pulses_left  <= (pulses_reg == 8'd0) ? 8'd1 : pulses_reg;
                        run_cnt      <= CNT_W'(1);
                        ph           <= SZ_W'(1);
                        if (offset == '0) begin
                            state    <= S_PULSE;
                            glitch_o <= pulse_lvl_c;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end

                S_WAIT: begin
                    glitch_o <= idle_lvl_c;
                    if (!run_i) begin
                        trunc <= 1'b1;
                        state <= S_ADVANCE;
                    end else if ((run_cnt == offset) && (run_cnt != CNT_MAX)) begin
                        state    <= S_PULSE;
                        ph       <= SZ_W'(1);
                        glitch_o <= pulse_lvl_c;
                    end else begin
                        run_cnt <= run_cnt_inc_c;
                    end
                end

                S_PULSE: begin
                    glitch_o <= idle_lvl_c;
                    if (!run_i) begin
                        trunc <= 1'b1;
                        state <= S_ADVANCE;
                    end else if (ph >= cur_size) begin
                        ph <= SZ_W'(1);
                        if (pulses_left > 8'd1) begin
                            pulses_left <= pulses_left - 8'd1;
                            state       <= S_GAP;
                        end else begin
                            pulses_left <= 8'd0;
                            state       <= S_HOLD;
                        end
                    end else begin
                        ph       <= ph + SZ_W'(1);
                        glitch_o <= pulse_lvl_c;
                    end
                end

                S_GAP: begin
                    glitch_o <= idle_lvl_c;
                    if (!run_i) begin
                        trunc <= 1'b1;
                        state <= S_ADVANCE;
                    end else if (ph >= SZ_W'(sh_gap)) begin
                        state    <= S_PULSE;
                        ph       <= SZ_W'(1);
                        glitch_o <= pulse_lvl_c;
                    end else begin
                        ph <= ph + SZ_W'(1);
                    end
                end

                S_HOLD: begin
                    glitch_o <= idle_lvl_c;
                    if (!run_i) begin
                        state <= S_ADVANCE;
                    end
                end

                S_ADVANCE: begin
                    // Sweep offset first; on wrap widen the pulse
                    glitch_o <= idle_lvl_c;
                    state    <= S_IDLE;
                    if (iter == sh_iter_max) begin
                        iter     <= 16'd0;
                        offset   <= '0;
                        cur_size <= size_sum_c;
                        if (size_sum_c > SZ_W'(sh_size_max)) begin
                            finished_o <= 1'b1;
                        end
                    end else begin
                        iter   <= iter + 16'd1;
                        offset <= off_next_c;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    glitch_o <= idle_lvl_c;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_deja_glitch_power_multi.sv
// Testbench for deja_glitch_power_multi: register table, directed sweeps and
// randomized sweeps against a window-level reference model.
module tb_deja_glitch_power_multi;

    localparam int CH = 2;

    logic          clk_i = 1'b0;
    logic          rst_n_i = 1'b0;
    logic          stb_i = 1'b0;
    logic          we_i = 1'b0;
    logic [3:0]    adr_i = 4'd0;
    logic [7:0]    dat_i = 8'd0;
    logic          ack_o;
    logic [7:0]    dat_o;
    logic          run_i = 1'b0;
    logic [CH-1:0] glitch_o;
    logic          finished_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    deja_glitch_power_multi #(.CHANNELS(CH), .CNT_W(32)) dut (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .stb_i      (stb_i),
        .we_i       (we_i),
        .adr_i      (adr_i),
        .dat_i      (dat_i),
        .ack_o      (ack_o),
        .dat_o      (dat_o),
        .run_i      (run_i),
        .glitch_o   (glitch_o),
        .finished_o (finished_o)
    );

    // Reference model state
    int     m_size_reg, m_step, m_en, m_pol, m_iter_max, m_size_step, m_size_max;
    int     m_pulses, m_gap, m_size, m_iter;
    longint m_offset;
    bit     m_fin, m_trunc;

    typedef struct {
        logic [3:0] adr;
        logic       we;
        logic [7:0] wd;
        logic       exp_ack;
        logic [7:0] exp_dat;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        m_size_reg = 1; m_step = 1; m_en = 'hFF; m_pol = 'hFF; m_iter_max = 0;
        m_size_step = 1; m_size_max = 1; m_pulses = 1; m_gap = 1;
        m_size = 1; m_iter = 0; m_offset = 0; m_fin = 0; m_trunc = 0;
    endtask

    task automatic bus(input logic [3:0] adr, input logic we, input logic [7:0] wd,
                       output logic ack, output logic [7:0] rd);
        @(negedge clk_i);
        stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd;
        @(negedge clk_i);
        ack = ack_o; rd = dat_o;
        stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic rd(input int adr, input int exp, input string name);
        logic a; logic [7:0] d;
        bus(4'(adr), 1'b0, 8'h00, a, d);
        check({name, "_ack"}, 32'(a), 32'd1);
        check(name, 32'(d), 32'(exp & 'hFF));
    endtask

    // Register write mirrored into the model
    task automatic cfg(input int adr, input int v);
        logic a; logic [7:0] d;
        bus(4'(adr), 1'b1, 8'(v), a, d);
        check($sformatf("wr_ack_a%0d", adr), 32'(a), 32'd1);
        case (adr)
            0:  m_size_reg = v;
            1:  m_step = v;
            3:  if (v % 2 == 1) begin
                    m_iter = 0; m_offset = 0; m_size = m_size_reg; m_fin = 0; m_trunc = 0;
                end
            4:  m_en = v;
            5:  m_pol = v;
            6:  m_iter_max = (m_iter_max & 'hFF00) | v;
            7:  m_iter_max = (m_iter_max & 'h00FF) | (v << 8);
            8:  m_size_step = v;
            9:  m_size_max = v;
            12: m_pulses = v;
            13: m_gap = v;
            default: ;
        endcase
    endtask

    // One run_i window of L clocks; expected trace from pulse start arithmetic
    task automatic run_window(input int L, input string tag);
        int sz, gp, np;
        longint e, s;
        bit act;
        logic [CH-1:0] en, pl, exp;
        sz = m_size;
        gp = (m_gap == 0) ? 1 : m_gap;
        np = (m_pulses == 0) ? 1 : m_pulses;
        en = m_en[CH-1:0];
        pl = m_pol[CH-1:0];
        @(negedge clk_i);
        run_i = 1'b1;
        for (int k = 0; k <= L; k++) begin
            @(negedge clk_i);
            act = 1'b0;
            if (!m_fin && k < L) begin
                for (int p = 0; p < np; p++) begin
                    s = m_offset + longint'(p) * (sz + gp);
                    if (k >= s && k < s + sz) act = 1'b1;
                end
            end
            exp = act ? (pl ^ en) : pl;
            check($sformatf("%s_k%0d", tag, k), 32'(glitch_o), 32'(exp));
            if (k == L - 1) run_i = 1'b0;
        end
        repeat (3) @(negedge clk_i);
        if (!m_fin) begin
            e = m_offset + longint'(np - 1) * (sz + gp) + sz;
            if (longint'(L) <= e) m_trunc = 1;
            if (m_iter == m_iter_max) begin
                m_iter = 0; m_offset = 0; m_size += m_size_step;
                if (m_size > m_size_max) m_fin = 1;
            end else begin
                m_iter++;
                m_offset += m_step;
                if (m_offset > 64'hFFFF_FFFF) m_offset = 64'hFFFF_FFFF;
            end
        end
        check({tag, "_finished"}, 32'(finished_o), 32'(m_fin));
        rd(2, (int'(m_trunc) << 2) | int'(m_fin), {tag, "_status"});
        rd(10, m_iter, {tag, "_iter_lo"});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic a; logic [7:0] d;
        model_reset();

        // Reset state
        #12;
        check("rst_glitch", 32'(glitch_o), 32'h3);
        check("rst_finished", 32'(finished_o), 32'd0);
        check("rst_ack", 32'(ack_o), 32'd0);
        check("rst_dat", 32'(dat_o), 32'd0);
        @(negedge clk_i);
        rst_n_i = 1'b1;

        // Register table: reset readback, RW/RO behaviour, unmapped addresses
        tbl.push_back('{4'd0,  1'b0, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{4'd1,  1'b0, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{4'd2,  1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd3,  1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd4,  1'b0, 8'h00, 1'b1, 8'hFF});
        tbl.push_back('{4'd5,  1'b0, 8'h00, 1'b1, 8'hFF});
        tbl.push_back('{4'd6,  1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd7,  1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd8,  1'b0, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{4'd9,  1'b0, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{4'd10, 1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd11, 1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd12, 1'b0, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{4'd13, 1'b0, 8'h00, 1'b1, 8'h01});
        tbl.push_back('{4'd14, 1'b0, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{4'd15, 1'b0, 8'h00, 1'b0, 8'h00});
        tbl.push_back('{4'd7,  1'b1, 8'h12, 1'b1, 8'h00});
        tbl.push_back('{4'd7,  1'b0, 8'h00, 1'b1, 8'h12});
        tbl.push_back('{4'd12, 1'b1, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd12, 1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd10, 1'b1, 8'h55, 1'b1, 8'h00});
        tbl.push_back('{4'd10, 1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd2,  1'b1, 8'hFF, 1'b1, 8'h00});
        tbl.push_back('{4'd2,  1'b0, 8'h00, 1'b1, 8'h00});
        tbl.push_back('{4'd14, 1'b1, 8'hAA, 1'b0, 8'h00});
        foreach (tbl[i]) begin
            bus(tbl[i].adr, tbl[i].we, tbl[i].wd, a, d);
            check($sformatf("tbl%0d_ack", i), 32'(a), 32'(tbl[i].exp_ack));
            if (!tbl[i].we) check($sformatf("tbl%0d_dat", i), 32'(d), 32'(tbl[i].exp_dat));
        end
        m_iter_max = 'h1200;
        m_pulses = 0;

        // Held strobe: ack every other cycle, never held
        @(negedge clk_i);
        stb_i = 1'b1; we_i = 1'b0; adr_i = 4'd0;
        @(negedge clk_i); check("held_ack1", 32'(ack_o), 32'd1);
        @(negedge clk_i); check("held_ack2", 32'(ack_o), 32'd0);
        stb_i = 1'b0;
        @(negedge clk_i);

        // Offset sweep with defaults and a wide iteration range
        cfg(6, 10); cfg(7, 0); cfg(12, 1); cfg(13, 1); cfg(3, 1);
        for (int w = 0; w < 3; w++) run_window(20, $sformatf("def_w%0d", w));
        rd(11, 0, "def_iter_hi");

        // Multi-pulse with gap, two iterations
        cfg(0, 3); cfg(1, 2); cfg(12, 2); cfg(13, 4); cfg(6, 1); cfg(3, 1);
        run_window(20, "mp_i0");
        run_window(20, "mp_i1");

        // Width sweep until finished, then run_i is ignored
        cfg(6, 0); cfg(0, 1); cfg(8, 2); cfg(9, 4); cfg(12, 1); cfg(1, 1); cfg(3, 1);
        run_window(12, "fin_w1");
        run_window(12, "fin_w3");
        check("fin_set", 32'(finished_o), 32'd1);
        run_window(12, "fin_none");
        cfg(3, 1);
        check("fin_clear", 32'(finished_o), 32'd0);

        // Polarity/enable and truncation mid-pulse
        cfg(5, 2); cfg(4, 1); cfg(0, 6); cfg(9, 20); cfg(6, 5); cfg(3, 1);
        run_window(3, "trunc");
        rd(2, 4, "trunc_status_hi");

        // Asynchronous reset mid-pulse
        cfg(5, 3); cfg(4, 3); cfg(0, 10); cfg(3, 1);
        @(negedge clk_i); run_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check("pre_rst_pulse", 32'(glitch_o), 32'h0);
        #2 rst_n_i = 1'b0;
        #1;
        check("async_rst_glitch", 32'(glitch_o), 32'h3);
        check("async_rst_fin", 32'(finished_o), 32'd0);
        run_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        model_reset();
        bus(4'd14, 1'b0, 8'h00, a, d);
        check("adr14_ack", 32'(a), 32'd0);
        check("adr14_dat", 32'(d), 32'd0);
        rd(0, 1, "post_rst_size");

        // Randomized sweeps
        for (int g = 0; g < 6; g++) begin
            cfg(0, $urandom_range(4, 1));
            cfg(1, $urandom_range(3, 0));
            cfg(12, $urandom_range(3, 0));
            cfg(13, $urandom_range(3, 0));
            cfg(6, $urandom_range(3, 0));
            cfg(8, $urandom_range(3, 0));
            cfg(9, $urandom_range(12, 1));
            cfg(4, $urandom_range(255, 0));
            cfg(5, $urandom_range(255, 0));
            cfg(3, 1);
            for (int w = 0; w < 6; w++)
                run_window($urandom_range(30, 1), $sformatf("rnd_g%0d_w%0d", g, w));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
